// File: rtl/alu_seq_pkg.sv
// Shared definitions for the wide sequential ALU controller.
//   W        : datapath width of the external alu64bit
//   OP_W     : opcode width passed through to alu64bit
//   state_t  : controller FSM states
//   is_arith : opcode class decode (op[1]=1 -> carry-chained arithmetic)
package alu_seq_pkg;

    localparam int W    = 64;
    localparam int OP_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_arith(input logic [OP_W-1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/alu_wide_seq.sv
// Multi-cycle wide ALU controller. Streams a WORDS x 64-bit operation through
// one shared external alu64bit, least significant word first, chaining the
// carry between words for arithmetic opcodes.
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   req_valid/req_ready         request handshake (accepted only in IDLE)
//   req_op, req_a, req_b, req_cin   request payload
//   rsp_valid/rsp_ready         response handshake (held in DONE)
//   rsp_s, rsp_cout             result and final carry (0 outside DONE)
//   busy                        high while an operation is in RUN or DONE
//   alu_a, alu_b, alu_op, alu_cin   drive the external alu64bit (0 unless RUN)
//   alu_s, alu_cout             combinational result from alu64bit
module alu_wide_seq
    import alu_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [OP_W-1:0]      req_op,
    input  logic [WORDS*W-1:0]   req_a,
    input  logic [WORDS*W-1:0]   req_b,
    input  logic                 req_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WORDS*W-1:0]   rsp_s,
    output logic                 rsp_cout,
    output logic                 busy,
    output logic [W-1:0]         alu_a,
    output logic [W-1:0]         alu_b,
    output logic [OP_W-1:0]      alu_op,
    output logic                 alu_cin,
    input  logic [W-1:0]         alu_s,
    input  logic                 alu_cout
);

    // WORDS=1 still needs a 1-bit index so the word select stays legal.
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t                     state;
    logic [IDX_W-1:0]           idx;
    logic [WORDS-1:0][W-1:0]    a_reg;
    logic [WORDS-1:0][W-1:0]    b_reg;
    logic [WORDS-1:0][W-1:0]    res_reg;
    logic [OP_W-1:0]            op_reg;
    logic                       carry_reg;
    logic                       cout_reg;
    logic                       arith;

    assign arith = is_arith(op_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            op_reg    <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_reg     <= req_a;
                        b_reg     <= req_b;
                        op_reg    <= req_op;
                        // Bitwise ops never see a carry, whatever req_cin says.
                        carry_reg <= is_arith(req_op) & req_cin;
                        idx       <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    res_reg[idx] <= alu_s;
                    carry_reg    <= arith & alu_cout;
                    if (idx == LAST_IDX) begin
                        cout_reg <= arith & alu_cout;
                        idx      <= '0;
                        state    <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    // No new request in the handshake cycle: IDLE first.
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Word-select mux toward the shared ALU; quiet outside RUN.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_op  = '0;
        alu_cin = 1'b0;
        if (state == RUN) begin
            alu_a   = a_reg[idx];
            alu_b   = b_reg[idx];
            alu_op  = op_reg;
            alu_cin = carry_reg;
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign rsp_s     = (state == DONE) ? res_reg : '0;
    assign rsp_cout  = (state == DONE) ? cout_reg : 1'b0;

endmodule
